// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the streaming XOR cipher.
// The FSM state encoding and the keystream mode constants live here so that
// the top-level controller and the keystream generator agree on them.

package xor_cipher_pkg;

    // Controller states:
    //   ST_IDLE      - no usable key is held
    //   ST_LOAD_KEY  - key bits are being shifted in serially
    //   ST_KEY_READY - a full key is held, waiting for a message frame
    //   ST_STREAM    - a message frame is in progress
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_KEY  = 2'd1,
        ST_KEY_READY = 2'd2,
        ST_STREAM    = 2'd3
    } cipher_state_e;

    // Keystream modes, sampled on the first bit of every frame.
    localparam logic MODE_REPEAT = 1'b0;
    localparam logic MODE_LFSR   = 1'b1;

endpackage : xor_cipher_pkg

// File: rtl/xor_keystream_gen.sv
// Keystream generator for the streaming XOR cipher.
// Holds the working register W and the per-frame mode. On the first bit of a
// frame W is seeded from the stored key; on every further consumed bit W
// advances either by rotation (repeating key) or by a Galois LFSR step.
// The keystream bit is always the MSB of the word in use for that bit.

module xor_keystream_gen
    import xor_cipher_pkg::*;
#(
    parameter int                  KEY_BITS  = 32,
    parameter logic [KEY_BITS-1:0] LFSR_TAPS = KEY_BITS'(32'h0400_0007)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                load_i,
    input  logic                advance_i,
    input  logic                mode_i,
    input  logic [KEY_BITS-1:0] key_i,
    output logic                ks_bit_o
);

    logic [KEY_BITS-1:0] w_q;
    logic [KEY_BITS-1:0] w_d;
    logic                mode_q;
    logic                mode_d;

    // One keystream step: rotate left in repeating mode, or shift left and
    // fold in the tap mask whenever a 1 falls out of the MSB in LFSR mode.
    // An all-zero word stays all-zero in LFSR mode, which simply gives a
    // zero keystream (plaintext passes through unchanged).
    function automatic logic [KEY_BITS-1:0] nextWord(
        input logic [KEY_BITS-1:0] w,
        input logic                m
    );
        logic [KEY_BITS-1:0] result;
        if (m == MODE_LFSR) begin
            result = {w[KEY_BITS-2:0], 1'b0} ^ (w[KEY_BITS-1] ? LFSR_TAPS : '0);
        end else begin
            result = {w[KEY_BITS-2:0], w[KEY_BITS-1]};
        end
        return result;
    endfunction

    // Next-state for W and the latched mode. A load uses the key word for the
    // current bit, so W is left holding the word for the following bit.
    always_comb begin
        w_d    = w_q;
        mode_d = mode_q;
        if (en_i) begin
            if (load_i) begin
                w_d    = nextWord(key_i, mode_i);
                mode_d = mode_i;
            end else if (advance_i) begin
                w_d = nextWord(w_q, mode_q);
            end
        end
    end

    // Working register and mode register, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_q    <= '0;
            mode_q <= MODE_REPEAT;
        end else begin
            w_q    <= w_d;
            mode_q <= mode_d;
        end
    end

    // On the seeding cycle W has not been loaded yet, so take the key MSB
    // directly; otherwise the MSB of the working register.
    assign ks_bit_o = load_i ? key_i[KEY_BITS-1] : w_q[KEY_BITS-1];

endmodule : xor_keystream_gen

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher top level.
// A key is shifted in serially (first bit becomes the MSB), then message bits
// are encrypted one per cycle with a registered, one-cycle-latency output.
// The stored key survives across frames, so back-to-back messages reuse it
// and each frame restarts the keystream from the key.

module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int                  KEY_BITS  = 32,
    parameter int                  MSG_BITS  = 512,
    parameter logic [KEY_BITS-1:0] LFSR_TAPS = KEY_BITS'(32'h0400_0007)
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iSerial_in,
    input  logic iLoad_key,
    input  logic iLoad_msg,
    input  logic iMode,
    output logic oSerial_out,
    output logic oSerial_valid,
    output logic oSerial_start,
    output logic oSerial_end,
    output logic oKey_ready,
    output logic oBusy
);

    localparam int KCW = $clog2(KEY_BITS + 1);
    localparam int MCW = $clog2(MSG_BITS + 1);

    localparam logic [KCW-1:0] KEY_CNT_LAST = KCW'(KEY_BITS - 1);
    localparam logic [MCW-1:0] MSG_CNT_LAST = MCW'(MSG_BITS - 1);
    localparam logic           SINGLE_BIT   = (MSG_BITS == 1);

    cipher_state_e       state_q;
    cipher_state_e       state_d;
    logic [KEY_BITS-1:0] key_q;
    logic [KEY_BITS-1:0] key_d;
    logic [KCW-1:0]      keyCnt_q;
    logic [KCW-1:0]      keyCnt_d;
    logic [MCW-1:0]      msgCnt_q;
    logic [MCW-1:0]      msgCnt_d;
    logic                keyReady_q;
    logic                keyReady_d;
    logic                out_q;
    logic                out_d;
    logic                valid_q;
    logic                valid_d;
    logic                start_q;
    logic                start_d;
    logic                end_q;
    logic                end_d;

    logic                ksLoad;
    logic                ksAdvance;
    logic                ksBit;

    xor_keystream_gen #(
        .KEY_BITS  (KEY_BITS),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_keystream (
        .clk_i     (iClk),
        .rst_i     (iRst),
        .en_i      (iEn),
        .load_i    (ksLoad),
        .advance_i (ksAdvance),
        .mode_i    (iMode),
        .key_i     (key_q),
        .ks_bit_o  (ksBit)
    );

    // Controller next-state logic. With iEn low every register holds its
    // value; otherwise the per-bit output flags default to 0 and are raised
    // only on cycles that actually consume a message bit.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        keyCnt_d   = keyCnt_q;
        msgCnt_d   = msgCnt_q;
        keyReady_d = keyReady_q;
        out_d      = out_q;
        valid_d    = valid_q;
        start_d    = start_q;
        end_d      = end_q;
        ksLoad     = 1'b0;
        ksAdvance  = 1'b0;

        if (iEn) begin
            valid_d = 1'b0;
            start_d = 1'b0;
            end_d   = 1'b0;

            case (state_q)
                ST_IDLE, ST_KEY_READY: begin
                    if (iLoad_key) begin
                        // Key load takes priority; the entry cycle already
                        // captures the first key bit.
                        state_d    = ST_LOAD_KEY;
                        key_d      = KEY_BITS'(iSerial_in);
                        keyCnt_d   = KCW'(1);
                        keyReady_d = 1'b0;
                    end else if (iLoad_msg && (state_q == ST_KEY_READY)) begin
                        // First bit of a frame: seed the keystream from the
                        // stored key and encrypt this bit in the same cycle.
                        ksLoad   = 1'b1;
                        out_d    = iSerial_in ^ ksBit;
                        valid_d  = 1'b1;
                        start_d  = 1'b1;
                        if (SINGLE_BIT) begin
                            end_d    = 1'b1;
                            msgCnt_d = '0;
                            state_d  = ST_KEY_READY;
                        end else begin
                            msgCnt_d = MCW'(1);
                            state_d  = ST_STREAM;
                        end
                    end
                end

                ST_LOAD_KEY: begin
                    if (iLoad_key) begin
                        key_d    = {key_q[KEY_BITS-2:0], iSerial_in};
                        keyCnt_d = keyCnt_q + KCW'(1);
                        if (keyCnt_q == KEY_CNT_LAST) begin
                            keyReady_d = 1'b1;
                            state_d    = ST_KEY_READY;
                        end
                    end else begin
                        // Early drop of the qualifier: the partial key is
                        // unusable, so throw it away.
                        key_d      = '0;
                        keyCnt_d   = '0;
                        keyReady_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end

                ST_STREAM: begin
                    if (iLoad_msg) begin
                        ksAdvance = 1'b1;
                        out_d     = iSerial_in ^ ksBit;
                        valid_d   = 1'b1;
                        if (msgCnt_q == MSG_CNT_LAST) begin
                            end_d    = 1'b1;
                            msgCnt_d = '0;
                            state_d  = ST_KEY_READY;
                        end else begin
                            msgCnt_d = msgCnt_q + MCW'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Controller state, key, counters and output registers; the asynchronous
    // reset aborts any frame in progress and discards the key.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            keyCnt_q   <= '0;
            msgCnt_q   <= '0;
            keyReady_q <= 1'b0;
            out_q      <= 1'b0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            keyCnt_q   <= keyCnt_d;
            msgCnt_q   <= msgCnt_d;
            keyReady_q <= keyReady_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            end_q      <= end_d;
        end
    end

    // The frozen flags are masked while iEn is low so a bit is only ever
    // presented as valid during an enabled cycle.
    assign oSerial_out   = out_q;
    assign oSerial_valid = valid_q & iEn;
    assign oSerial_start = start_q & iEn;
    assign oSerial_end   = end_q & iEn;
    assign oKey_ready    = keyReady_q;
    assign oBusy         = (state_q == ST_STREAM);

endmodule : xor_stream_cipher

// File: tb/tb_xor_stream_cipher.sv
// Directed testbench for xor_stream_cipher with KEY_BITS=8, MSG_BITS=16,
// LFSR_TAPS=8'h1D. Expected ciphertexts are hand-computed constants.

module tb_xor_stream_cipher;

    logic iClk = 1'b0;
    logic iRst;
    logic iEn;
    logic iSerial_in;
    logic iLoad_key;
    logic iLoad_msg;
    logic iMode;
    logic oSerial_out;
    logic oSerial_valid;
    logic oSerial_start;
    logic oSerial_end;
    logic oKey_ready;
    logic oBusy;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] cipher;

    xor_stream_cipher #(
        .KEY_BITS  (8),
        .MSG_BITS  (16),
        .LFSR_TAPS (8'h1D)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iEn           (iEn),
        .iSerial_in    (iSerial_in),
        .iLoad_key     (iLoad_key),
        .iLoad_msg     (iLoad_msg),
        .iMode         (iMode),
        .oSerial_out   (oSerial_out),
        .oSerial_valid (oSerial_valid),
        .oSerial_start (oSerial_start),
        .oSerial_end   (oSerial_end),
        .oKey_ready    (oKey_ready),
        .oBusy         (oBusy)
    );

    // Free-running 10-unit clock.
    always #5 iClk = ~iClk;

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, settle 1 unit.
    task automatic applyStimulus(input logic en, input logic lk, input logic lm,
                                 input logic sin, input logic mode);
        iEn        = en;
        iLoad_key  = lk;
        iLoad_msg  = lm;
        iSerial_in = sin;
        iMode      = mode;
        @(posedge iClk);
        #1;
    endtask

    // Serial key load, MSB first; ready must only rise with the last bit.
    task automatic loadKey(input logic [7:0] key);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, key[7-i], 1'b0);
            checkOutput("key_ready_during_load", {31'd0, oKey_ready}, {31'd0, (i == 7)});
        end
        checkOutput("busy_after_key_load", {31'd0, oBusy}, 32'd0);
    endtask

    // Send one 16-bit frame MSB first. iMode is inverted after the first bit
    // to show it is only sampled at frame start. Optional flow-control stall
    // (iLoad_msg low, iLoad_key high to show it is ignored) and iEn-low gap
    // are inserted before the bits with index stallAt and enOffAt.
    task automatic sendFrame(input logic [15:0] msg, input logic mode,
                             input int stallAt, input int stallLen,
                             input int enOffAt, input int enOffLen,
                             output logic [15:0] ct);
        ct = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == stallAt) begin
                for (int s = 0; s < stallLen; s++) begin
                    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, ~mode);
                    checkOutput("stall_valid", {31'd0, oSerial_valid}, 32'd0);
                    checkOutput("stall_busy", {31'd0, oBusy}, 32'd1);
                end
            end
            if (i == enOffAt) begin
                for (int s = 0; s < enOffLen; s++) begin
                    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, ~mode);
                    checkOutput("en_off_valid", {31'd0, oSerial_valid}, 32'd0);
                    checkOutput("en_off_start_end", {30'd0, oSerial_start, oSerial_end}, 32'd0);
                end
            end
            applyStimulus(1'b1, 1'b0, 1'b1, msg[15-i], (i == 0) ? mode : ~mode);
            checkOutput("frame_valid", {31'd0, oSerial_valid}, 32'd1);
            checkOutput("frame_start", {31'd0, oSerial_start}, {31'd0, (i == 0)});
            checkOutput("frame_end", {31'd0, oSerial_end}, {31'd0, (i == 15)});
            checkOutput("frame_key_ready", {31'd0, oKey_ready}, 32'd1);
            checkOutput("frame_busy", {31'd0, oBusy}, {31'd0, (i != 15)});
            ct[15-i] = oSerial_out;
        end
    endtask

    initial begin
        iRst       = 1'b1;
        iEn        = 1'b0;
        iSerial_in = 1'b0;
        iLoad_key  = 1'b0;
        iLoad_msg  = 1'b0;
        iMode      = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        checkOutput("reset_outputs",
                    {26'd0, oSerial_out, oSerial_valid, oSerial_start, oSerial_end, oKey_ready, oBusy},
                    32'd0);
        iRst = 1'b0;

        // Message qualifier with no key is ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("idle_msg_valid", {31'd0, oSerial_valid}, 32'd0);
        checkOutput("idle_msg_busy", {31'd0, oBusy}, 32'd0);

        $display("[TB] key A5, repeating mode, message 0000");
        loadKey(8'hA5);
        sendFrame(16'h0000, 1'b0, -1, 0, -1, 0, cipher);
        checkOutput("repeat_0000", {16'd0, cipher}, 32'h0000_A5A5);

        $display("[TB] back-to-back frame, message FFFF");
        sendFrame(16'hFFFF, 1'b0, -1, 0, -1, 0, cipher);
        checkOutput("repeat_ffff", {16'd0, cipher}, 32'h0000_5A5A);

        $display("[TB] stalled frame, message 0000");
        sendFrame(16'h0000, 1'b0, 4, 3, 9, 2, cipher);
        checkOutput("stalled_0000", {16'd0, cipher}, 32'h0000_A5A5);

        $display("[TB] key 80, LFSR mode, message 0000");
        loadKey(8'h80);
        sendFrame(16'h0000, 1'b1, -1, 0, -1, 0, cipher);
        checkOutput("lfsr_first_byte", {24'd0, cipher[15:8]}, 32'h0000_008E);
        checkOutput("lfsr_full_frame", {16'd0, cipher}, 32'h0000_8E25);

        $display("[TB] key load aborted after 5 bits");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_key_ready", {31'd0, oKey_ready}, 32'd0);
        checkOutput("abort_busy", {31'd0, oBusy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput("abort_msg_valid", {31'd0, oSerial_valid}, 32'd0);
        end
        loadKey(8'hA5);
        sendFrame(16'h0000, 1'b0, -1, 0, -1, 0, cipher);
        checkOutput("reload_0000", {16'd0, cipher}, 32'h0000_A5A5);

        $display("[TB] reset during bit 7 of a frame");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("pre_reset_out", {30'd0, oSerial_out, oSerial_valid}, 32'd3);
        checkOutput("pre_reset_busy", {31'd0, oBusy}, 32'd1);
        #2;
        iRst = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    {26'd0, oSerial_out, oSerial_valid, oSerial_start, oSerial_end, oKey_ready, oBusy},
                    32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput("post_reset_valid", {31'd0, oSerial_valid}, 32'd0);
            checkOutput("post_reset_key_ready", {31'd0, oKey_ready}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_xor_stream_cipher
